dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//   Upstream frequency-sweep sequencer for the DDS generator stage.
//   Steps a 32-bit frequency tuning word from f_start towards f_stop in
//   f_step increments, holding each point for a programmable dwell.
//   Drives the generator's fword / pword / en inputs and flags each step,
//   so downstream tracking logic can sample the response per point.
// PARAMETERS
//   FW_W     32  width of frequency tuning word (phase accumulator width)
//   PW_W     11  width of phase offset word (ROM address width)
//   DWELL_W  24  width of dwell counter, in clk cycles
//   IDX_W    16  width of step index counter
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        asynchronous reset, active-low
//   start      in   1        1-cycle pulse: latch config and begin sweep (honoured in IDLE only)
//   abort      in   1        level/pulse: terminate sweep, return to IDLE
//   cont       in   1        1 = restart from f_start after the last point; 0 = single sweep
//   f_start    in   FW_W     first tuning word
//   f_stop     in   FW_W     last tuning word (inclusive upper bound)
//   f_step     in   FW_W     tuning-word increment per point
//   dwell      in   DWELL_W  clk cycles per point (0 treated as 1)
//   pword_in   in   PW_W     phase offset, latched at start
//   fword      out  FW_W     tuning word to DDS generator
//   pword      out  PW_W     phase offset to DDS generator
//   dds_en     out  1        enable to DDS generator (high while RUN)
//   busy       out  1        high in RUN
//   step_tick  out  1        1-cycle pulse in the cycle fword takes a new value (incl. first point)
//   step_idx   out  IDX_W    index of current point, 0 at f_start, wraps modulo 2^IDX_W
//   done       out  1        1-cycle pulse when a single sweep completes
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE, latched config cleared.
//   States: IDLE, RUN, FIN.
//   IDLE: on start=1 (and abort=0), latch f_start/f_stop/f_step/dwell/pword_in/cont;
//     next cycle: state RUN, fword=f_start, pword=pword_in, dds_en=1, busy=1,
//     step_idx=0, step_tick=1, dwell counter=0. start outside IDLE is ignored.
//   RUN: dwell counter increments every cycle. When counter == max(dwell,1)-1:
//     nxt = {1'b0,fword} + {1'b0,f_step} (FW_W+1 bits, no wrap).
//     if f_step!=0 and nxt <= f_stop: fword<=nxt[FW_W-1:0], step_idx++,
//       step_tick=1, counter<=0; stay RUN.
//     else (last point): if cont: fword<=f_start, step_idx<=0, step_tick=1,
//       counter<=0, stay RUN; else go FIN.
//   FIN: one cycle; done=1, dds_en=0, busy=0, fword/pword hold last value;
//     next cycle IDLE. start in FIN ignored.
//   Degenerate configs: f_start >= f_stop or f_step==0 -> single point sweep
//     (one dwell at f_start, then FIN; with cont=1, repeats f_start forever).
//   abort=1 in any state: next cycle IDLE, dds_en=0, busy=0, done=0,
//     step_tick=0; fword/pword hold. abort has priority over start and dwell expiry.
//   Config inputs ignored after latching; changes mid-sweep have no effect.
//   Async rst mid-sweep: immediate return to reset values.
//   Note: DDS generator adds accumulator + address + ROM latency; step_tick
//     marks the fword change, consumers apply their own pipeline offset.
// TESTING
//   1. start, f_start=1000,f_stop=1300,f_step=100,dwell=4,cont=0 -> fword 1000,1100,
//      1200,1300 each 4 cycles; 4 step_ticks; step_idx 0..3; done 1 cycle after last dwell.
//   2. Same with cont=1 -> after 1300 fword returns to 1000, step_idx=0, no done; abort
//      -> IDLE next cycle, dds_en=0.
//   3. f_start=32'hFFFF_FF00,f_stop=32'hFFFF_FFFF,f_step=32'h80 -> points FF00,FF80 only,
//      no wrap to low values, then done.
//   4. dwell=0, f_step=0 -> single point at f_start held 1 cycle, done next cycle.
//   5. start pulsed during RUN and FIN, config changed mid-sweep -> no effect on sequence.
//   6. rst deasserted->asserted mid-RUN -> all outputs 0 same cycle; new start works normally.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS generator.
// Steps fword from f_start to f_stop in f_step increments, holding each point
// for a programmable dwell, and optionally restarts after the last point.
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int PW_W    = 11,
  parameter int DWELL_W = 24,
  parameter int IDX_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PW_W-1:0]    pword_in,
  output logic [FW_W-1:0]    fword,
  output logic [PW_W-1:0]    pword,
  output logic               dds_en,
  output logic               busy,
  output logic               step_tick,
  output logic [IDX_W-1:0]   step_idx,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [FW_W-1:0]    start_r, stop_r, step_r;
  logic [DWELL_W-1:0] dwell_last;   // last counter value of a point (dwell 0 acts as 1)
  logic [DWELL_W-1:0] cnt;
  logic               cont_r;

  logic [FW_W:0]      nxt;
  logic               adv;
  logic               expire;

  // Next point is computed one bit wider so overflow past 2^FW_W ends the sweep
  assign nxt    = {1'b0, fword} + {1'b0, step_r};
  assign adv    = (step_r != '0) && (nxt <= {1'b0, stop_r});
  assign expire = (cnt == dwell_last);

  // Sweep FSM with registered outputs; abort overrides everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_r    <= '0;
      stop_r     <= '0;
      step_r     <= '0;
      dwell_last <= '0;
      cnt        <= '0;
      cont_r     <= 1'b0;
      fword      <= '0;
      pword      <= '0;
      dds_en     <= 1'b0;
      busy       <= 1'b0;
      step_tick  <= 1'b0;
      step_idx   <= '0;
      done       <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        dds_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            start_r    <= f_start;
            stop_r     <= f_stop;
            step_r     <= f_step;
            dwell_last <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            cont_r     <= cont;
            fword      <= f_start;
            pword      <= pword_in;
            dds_en     <= 1'b1;
            busy       <= 1'b1;
            step_idx   <= '0;
            step_tick  <= 1'b1;
            cnt        <= '0;
            state      <= RUN;
          end
          RUN: begin
            if (!expire) begin
              cnt <= cnt + DWELL_W'(1);
            end else if (adv) begin
              fword     <= nxt[FW_W-1:0];
              step_idx  <= step_idx + IDX_W'(1);
              step_tick <= 1'b1;
              cnt       <= '0;
            end else if (cont_r) begin
              fword     <= start_r;
              step_idx  <= '0;
              step_tick <= 1'b1;
              cnt       <= '0;
            end else begin
              state  <= FIN;
              done   <= 1'b1;
              dds_en <= 1'b0;
              busy   <= 1'b0;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: each sweep's expected tick/done events
// (value, index and cycle) are derived from the point list and queued; a monitor
// pops and compares whenever the DUT flags step_tick or done.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cont = 1'b0;
  logic [31:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [23:0] dwell = '0;
  logic [10:0] pword_in = '0;
  logic [31:0] fword;
  logic [10:0] pword;
  logic        dds_en, busy, step_tick, done;
  logic [15:0] step_idx;

  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .pword_in(pword_in), .fword(fword), .pword(pword), .dds_en(dds_en),
    .busy(busy), .step_tick(step_tick), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] fw;
    logic [15:0] idx;
    logic [10:0] pw;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every tick/done the DUT presents must match the head of the queue
  always @(negedge clk) begin
    ev_t e;
    if (rst && (step_tick || done)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: tick=%0b done=%0b fword=%0h with no expectation (cycle %0d)",
                 step_tick, done, fword, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind_done", {63'b0, done}, {63'b0, e.is_done});
        chk("event_kind_tick", {63'b0, step_tick}, {63'b0, !e.is_done});
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("fword", {32'b0, fword}, {32'b0, e.fw});
        chk("step_idx", {48'b0, step_idx}, {48'b0, e.idx});
        chk("pword", {53'b0, pword}, {53'b0, e.pw});
        chk("dds_en", {63'b0, dds_en}, {63'b0, !e.is_done});
        chk("busy", {63'b0, busy}, {63'b0, !e.is_done});
      end
    end
  end

  function automatic ev_t mk(input bit d, input logic [31:0] fw, input int idx,
                             input logic [10:0] pw, input int c);
    ev_t e;
    e.is_done = d; e.fw = fw; e.idx = 16'(idx); e.pw = pw; e.cyc = c;
    return e;
  endfunction

  // Issue start with a config and queue the expected event stream
  task automatic launch(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                        input logic [23:0] dw, input bit ct, input logic [10:0] pw,
                        input int rounds, output int t_end);
    longint unsigned p;
    logic [31:0]     pts[$];
    int              d, t0, n;
    @(negedge clk);
    start = 1'b1; f_start = fs; f_stop = fe; f_step = st; dwell = dw; cont = ct; pword_in = pw;
    t0 = cyc + 1;
    d  = (dw == 0) ? 1 : int'(dw);
    pts.push_back(fs);
    if (st != 0) begin
      p = {32'b0, fs} + {32'b0, st};
      while (p <= {32'b0, fe}) begin
        pts.push_back(p[31:0]);
        p = p + {32'b0, st};
      end
    end
    n = pts.size();
    if (!ct) begin
      for (int k = 0; k < n; k++) q.push_back(mk(1'b0, pts[k], k, pw, t0 + k * d));
      q.push_back(mk(1'b1, pts[n-1], n - 1, pw, t0 + n * d));
      t_end = t0 + n * d;
    end else begin
      for (int k = 0; k <= rounds * n; k++) q.push_back(mk(1'b0, pts[k % n], k % n, pw, t0 + k * d));
      t_end = t0 + rounds * n * d;   // abort lands right after this tick
    end
  endtask

  // Run the sweep to its end, optionally pulsing start and scrambling config meanwhile
  task automatic finish(input int t_end, input bit ct, input bit noise);
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (noise) begin
        start = ($urandom_range(0, 2) == 0);
        f_start = $urandom; f_stop = $urandom; f_step = $urandom;
        dwell = 24'($urandom_range(0, 7)); cont = 1'($urandom); pword_in = 11'($urandom);
      end
      if (ct && cyc >= t_end) abort = 1'b1;
      if (cyc >= t_end) break;
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_dds_en", {63'b0, dds_en}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);
    chk("idle_done", {63'b0, done}, 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                       input logic [23:0] dw, input bit ct, input int rounds, input bit noise);
    int t_end;
    launch(fs, fe, st, dw, ct, 11'($urandom), rounds, t_end);
    finish(t_end, ct, noise);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_end;
    logic [31:0] fs, st, fe;
    // reset state
    #23;
    chk("rst_fword", {32'b0, fword}, 64'd0);
    chk("rst_outs", {53'b0, pword, dds_en, busy, step_tick, done}, 64'd0);
    chk("rst_idx", {48'b0, step_idx}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    sweep(32'd1000, 32'd1300, 32'd100, 24'd4, 1'b0, 0, 1'b0);        // basic single sweep
    sweep(32'd1000, 32'd1300, 32'd100, 24'd4, 1'b1, 2, 1'b0);        // continuous, then abort
    sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd3, 1'b0, 0, 1'b0); // no wrap past top
    sweep(32'd555, 32'd9000, 32'd0, 24'd0, 1'b0, 0, 1'b0);           // dwell 0, step 0
    sweep(32'd7000, 32'd100, 32'd50, 24'd2, 1'b0, 0, 1'b0);          // start above stop
    sweep(32'd42, 32'd42, 32'd0, 24'd2, 1'b1, 3, 1'b0);              // single point repeating
    sweep(32'd1000, 32'd1300, 32'd100, 24'd4, 1'b0, 0, 1'b1);        // start/config noise

    // async reset in the middle of a long-dwell sweep
    launch(32'd10, 32'd100, 32'd10, 24'd20, 1'b0, 11'h5A5, 0, t_end);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_fword", {32'b0, fword}, 64'd0);
    chk("midrst_outs", {53'b0, pword, dds_en, busy, step_tick, done}, 64'd0);
    chk("midrst_idx", {48'b0, step_idx}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sweep(32'd1000, 32'd1300, 32'd100, 24'd4, 1'b0, 0, 1'b0);

    // randomized sweeps
    for (int i = 0; i < 20; i++) begin
      fs = $urandom & 32'h7FFF_FFFF;
      st = (i % 5 == 4) ? 32'd0 : 32'($urandom_range(1, 1000));
      fe = (i % 7 == 6) ? fs - 32'($urandom_range(1, 50))
                        : fs + st * 32'($urandom_range(0, 6)) + 32'($urandom_range(0, 999));
      sweep(fs, fe, st, 24'($urandom_range(0, 5)), 1'($urandom), $urandom_range(1, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
